// File: rtl/mult_pkg.sv
// Shared definitions for the signed shift-and-add multiplier: controller states,
// default operand width and the iteration counter sizing.
package mult_pkg;

  localparam int MULT_WIDTH = 16;
  localparam int CNT_W      = $clog2(MULT_WIDTH);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_SIGN = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Counter must still be at least one bit wide for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle shared with the companion divider: start plus operands in,
// product with busy/done status out.
interface shift_add_multiplier_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   P;
  logic                 busy;
  logic                 done;

  modport master (
    output start, A, B,
    input  P, busy, done
  );

  modport slave (
    input  start, A, B,
    output P, busy, done
  );

endinterface

// File: rtl/mult_datapath.sv
// Magnitude shift-and-add datapath: operand registers, accumulator with carry,
// iteration counter and the final sign application into the product register.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_ld_ops,
  input  logic                 i_step,
  input  logic                 i_ld_p,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_p,
  output logic                 o_cnt_zero
);

  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mult;
  logic [WIDTH:0]     r_acc;
  logic               r_neg;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mag;
  logic [2*WIDTH-1:0] w_signed;

  // Negating the most-negative value wraps to itself, which is its correct unsigned magnitude.
  assign w_mag_a = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_mag_b = i_b[WIDTH-1] ? -i_b : i_b;

  // r_acc's top bit is always clear after a shift, so adding the full register
  // is the same as adding only its low WIDTH bits.
  assign w_sum    = r_mult[0] ? (r_acc + {1'b0, r_mcand}) : r_acc;
  assign w_mag    = {r_acc[WIDTH-1:0], r_mult};
  assign w_signed = r_neg ? -w_mag : w_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand <= '0;
      r_mult  <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      if (i_ld_ops) begin
        r_mcand <= w_mag_a;
        r_mult  <= w_mag_b;
        r_acc   <= '0;
        r_neg   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
        r_cnt   <= CNT_INIT;
      end else if (i_step) begin
        r_acc  <= w_sum >> 1;
        r_mult <= {w_sum[0], r_mult[WIDTH-1:1]};
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CNT_ONE;
        end
      end
      if (i_ld_p) begin
        r_p <= w_signed;
      end
    end
  end

  assign o_p        = r_p;
  assign o_cnt_zero = (r_cnt == '0);

endmodule

// File: rtl/shift_add_multiplier.sv
// Signed sequential multiplier: controller FSM sequencing one partial product per clock
// through mult_datapath, then a sign step and a single-cycle done pulse.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_add_multiplier_if.slave bus
);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_ld_ops;
  logic               w_step;
  logic               w_ld_p;
  logic               w_cnt_zero;
  logic [2*WIDTH-1:0] w_p;

  assign w_ld_ops = (r_state == ST_IDLE) && bus.start;
  assign w_step   = (r_state == ST_CALC);
  assign w_ld_p   = (r_state == ST_SIGN);

  // Latency is fixed: the counter always runs all WIDTH iterations, no zero shortcut.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.start) w_state_next = ST_CALC;
      ST_CALC: if (w_cnt_zero) w_state_next = ST_SIGN;
      ST_SIGN: w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .i_ld_ops   (w_ld_ops),
    .i_step     (w_step),
    .i_ld_p     (w_ld_p),
    .i_a        (bus.A),
    .i_b        (bus.B),
    .o_p        (w_p),
    .o_cnt_zero (w_cnt_zero)
  );

  assign bus.P    = w_p;
  assign bus.busy = (r_state == ST_CALC) || (r_state == ST_SIGN);
  assign bus.done = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Testbench for shift_add_multiplier: directed corner products plus randomized traffic
// against a cycle-count/arithmetic reference model.
module tb_shift_add_multiplier;
  import mult_pkg::*;

  localparam int W   = MULT_WIDTH;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint prod;
    prod = longint'($signed(a)) * longint'($signed(b));
    return prod[2*W-1:0];
  endfunction

  // Reference: m_cnt counts cycles since an accepted start (0 = idle).
  int             m_cnt;
  logic [2*W-1:0] m_p;
  logic [2*W-1:0] m_pend;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0;
      m_p   <= '0;
    end else if (m_cnt == 0) begin
      if (bus.start) begin
        m_cnt  <= 1;
        m_pend <= ref_mul(bus.A, bus.B);
      end
    end else if (m_cnt == LAT) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == LAT - 1) m_p <= m_pend;
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(bus.busy), 64'(m_cnt >= 1 && m_cnt < LAT));
      check("done", 64'(bus.done), 64'(m_cnt == LAT));
      check("P",    64'(bus.P),    64'(m_p));
    end
  end

  task automatic wait_done(output int lat, output int nbusy, output logic [2*W-1:0] p);
    lat   = -1;
    nbusy = 0;
    p     = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        p   = bus.P;
        break;
      end
      if (bus.busy) nbusy++;
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #2;
    bus.A = a; bus.B = b; bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom % 8)
      0: v = '0;
      1: v = W'(1);
      2: v = '1;
      3: v = {1'b1, {(W-1){1'b0}}};
      4: v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[7] = '{
    '{16'h0003, 16'h0005, 32'h0000000F},
    '{16'hFFF9, 16'h0006, 32'hFFFFFFD6},
    '{16'h0000, 16'hFFFF, 32'h00000000},
    '{16'h8000, 16'h8000, 32'h40000000},
    '{16'h8000, 16'h0001, 32'hFFFF8000},
    '{16'h7FFF, 16'h7FFF, 32'h3FFF0001},
    '{16'h7FFF, 16'h8000, 32'hC0008000}
  };

  int             lat;
  int             nbusy;
  logic [2*W-1:0] p;

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0;
    @(posedge clk); #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset_P",    64'(bus.P),    64'h0);
    check("reset_busy", 64'(bus.busy), 64'h0);
    check("reset_done", 64'(bus.done), 64'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(lat, nbusy, p);
      $display("op %0d: A=0x%h B=0x%h -> P=0x%h latency=%0d", i, vecs[i].a, vecs[i].b, p, lat);
      check("dir_P",       64'(p),   64'(vecs[i].p));
      check("model_P",     64'(m_p), 64'(vecs[i].p));
      check("dir_latency", 64'(lat), 64'(LAT));
      if (i == 0) check("busy_cycles", 64'(nbusy), 64'(LAT - 1));
    end

    // Start during CALC must be ignored.
    issue(16'd3, 16'd5);
    repeat (4) @(posedge clk);
    #2 bus.A = 16'd9; bus.B = 16'd9; bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    wait_done(lat, nbusy, p);
    $display("ignored start: P=0x%h latency_from_pulse=%0d", p, lat);
    check("ignore_P", 64'(p), 64'd15);
    issue(16'd9, 16'd9);
    wait_done(lat, nbusy, p);
    $display("fresh 9x9: P=0x%h latency=%0d", p, lat);
    check("fresh_P",   64'(p),   64'd81);
    check("fresh_lat", 64'(lat), 64'(LAT));

    // Reset during the 8th cycle of CALC.
    issue(16'd3, 16'd5);
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    $display("mid-CALC reset: busy=%0b done=%0b P=0x%h", bus.busy, bus.done, bus.P);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_P",    64'(bus.P),    64'h0);
    issue(16'hFFFE, 16'hFFFD);
    wait_done(lat, nbusy, p);
    $display("-2 x -3: P=0x%h latency=%0d", p, lat);
    check("post_rst_P",   64'(p),   64'd6);
    check("post_rst_lat", 64'(lat), 64'(LAT));

    // Randomized traffic, including starts held through DONE and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      bus.start = (($urandom % 3) == 0);
      bus.A     = pick();
      bus.B     = pick();
      reset     = (($urandom % 400) == 0);
      if (bus.done) $display("random: done P=0x%h", bus.P);
    end
    @(posedge clk); #2;
    reset = 1'b0; bus.start = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
